// File: rtl/char_jump_ctrl_if.sv
// -----------------------------------------------------------------------------
// char_jump_ctrl_if
// Signal bundle between the input/collision side and the character motion
// engine. Clock and reset stay plain ports on the engine.
//
// Protocol: phy_tick is a one-cycle strobe, once per frame, and it qualifies
// every input. left/right/jump/ground_hit/ground_y are sampled only on the
// cycle phy_tick is high. All outputs are registered and change only in the
// cycle after a tick (or after reset). jump_start and land are one-cycle
// pulses in that cycle and are never high together. There is no back-pressure.
//
// Signals
//   phy_tick    engine input   one-cycle physics strobe
//   left        engine input   debounced level
//   right       engine input   debounced level
//   jump        engine input   debounced level
//   ground_hit  engine input   feet on a platform top at ground_y
//   ground_y    engine input   platform top y used for the landing snap
//   char_abs_x  engine output  character x (absolute map coordinate)
//   char_abs_y  engine output  character y (absolute map coordinate, y up)
//   state       engine output  00 IDLE, 01 CHARGE, 10 AIR
//   charge_lvl  engine output  current jump charge
//   facing      engine output  0 left, 1 right
//   jump_start  engine output  one-cycle pulse at launch
//   land        engine output  one-cycle pulse at landing
//
// Modports: master drives the inputs (stimulus/collision side),
//           slave is the motion engine.
// -----------------------------------------------------------------------------
interface char_jump_ctrl_if #(
  parameter int PHY_WIDTH    = 16,
  parameter int CHARGE_WIDTH = 5
);
  logic                    phy_tick;
  logic                    left;
  logic                    right;
  logic                    jump;
  logic                    ground_hit;
  logic [PHY_WIDTH-1:0]    ground_y;
  logic [PHY_WIDTH-1:0]    char_abs_x;
  logic [PHY_WIDTH-1:0]    char_abs_y;
  logic [1:0]              state;
  logic [CHARGE_WIDTH-1:0] charge_lvl;
  logic                    facing;
  logic                    jump_start;
  logic                    land;

  modport master (
    output phy_tick, left, right, jump, ground_hit, ground_y,
    input  char_abs_x, char_abs_y, state, charge_lvl, facing, jump_start, land
  );

  modport slave (
    input  phy_tick, left, right, jump, ground_hit, ground_y,
    output char_abs_x, char_abs_y, state, charge_lvl, facing, jump_start, land
  );
endinterface

// File: rtl/char_jump_ctrl.sv
// -----------------------------------------------------------------------------
// char_jump_ctrl
// Character motion engine. Turns debounced left/right/jump levels into an
// absolute map position (y up) with per-frame physics: walking, a
// charge-and-release jump, gravity with a terminal fall speed, wall clamping
// and landing on the floor or on a platform reported by the collision unit.
//
// Ports
//   sys_clk   in   system clock
//   sys_rst   in   synchronous reset, active-high
//   bus       char_jump_ctrl_if.slave (tick, buttons, collision in;
//             position, state, charge, facing, jump_start/land pulses out)
//
// Build option
//   CHAR_WALL_BOUNCE_EN  defined: a wall hit in the air reflects vx and flips
//                        facing. Undefined: a wall hit zeroes vx so the
//                        character slides down the wall. vy is never touched
//                        by a wall hit.
//
// The FSM state is visible on bus.state (00 IDLE, 01 CHARGE, 10 AIR).
// -----------------------------------------------------------------------------
module char_jump_ctrl #(
  parameter int PHY_WIDTH    = 16,
  parameter int VEL_WIDTH    = 8,
  parameter int CHARGE_WIDTH = 5,
  parameter int MAX_CHARGE   = 20,
  parameter int MAP_X_OFFSET = 140,
  parameter int MAP_WIDTH_X  = 480,
  parameter int WALL_WIDTH   = 10,
  parameter int CHAR_WIDTH_X = 42,
  parameter int FLOOR_Y      = 10,
  parameter int INIT_X       = 359,
  parameter int WALK_SPEED   = 2,
  parameter int JUMP_VX      = 4,
  parameter int JUMP_STEP_Y  = 2,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  char_jump_ctrl_if.slave  bus
);

  // Positions are worked out one bit wider and signed so that a step past
  // either edge shows up as a value outside the legal range instead of a wrap.
  localparam int SW = PHY_WIDTH + 1;
  localparam int VW = VEL_WIDTH;
  localparam int CW = CHARGE_WIDTH;

  localparam logic signed [SW-1:0] C_XMIN  = SW'(MAP_X_OFFSET + WALL_WIDTH);
  localparam logic signed [SW-1:0] C_XMAX  = SW'(MAP_X_OFFSET + MAP_WIDTH_X
                                                 - WALL_WIDTH - CHAR_WIDTH_X);
  localparam logic signed [SW-1:0] C_FLOOR = SW'(FLOOR_Y);
  localparam logic signed [SW-1:0] C_YMAX  = $signed({1'b0, {PHY_WIDTH{1'b1}}});
  localparam logic signed [SW-1:0] C_WALK  = SW'(WALK_SPEED);

  localparam logic signed [VW-1:0] C_JUMP_VX  = VW'(JUMP_VX);
  localparam logic signed [VW-1:0] C_GRAV     = VW'(GRAVITY);
  localparam logic signed [VW-1:0] C_FALL_LIM = VW'(-MAX_FALL);

  localparam logic [PHY_WIDTH-1:0] C_INIT_X  = PHY_WIDTH'(INIT_X);
  localparam logic [PHY_WIDTH-1:0] C_FLOOR_U = PHY_WIDTH'(FLOOR_Y);
  localparam logic [CW-1:0]        C_MAX_CHG = CW'(MAX_CHARGE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CHARGE = 2'b01,
    S_AIR    = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic [PHY_WIDTH-1:0]    r_x;
  logic [PHY_WIDTH-1:0]    r_y;
  logic signed [VW-1:0]    r_vx;
  logic signed [VW-1:0]    r_vy;
  logic [CW-1:0]           r_charge;
  logic                    r_facing;
  logic                    r_jump_start;
  logic                    r_land;

  // ---------------------------------------------------------------------------
  // Combinational next-value helpers
  // ---------------------------------------------------------------------------
  logic                    w_dir_l;
  logic                    w_dir_r;
  logic signed [SW-1:0]    w_x_ext;
  logic signed [SW-1:0]    w_y_ext;
  logic signed [SW-1:0]    w_walk_sum;
  logic [PHY_WIDTH-1:0]    w_walk_x;
  logic signed [SW-1:0]    w_air_sum;
  logic [PHY_WIDTH-1:0]    w_air_x;
  logic                    w_wall_hit;
  logic signed [SW-1:0]    w_y_sum;
  logic [PHY_WIDTH-1:0]    w_air_y;
  logic                    w_vy_falling;
  logic                    w_land_gnd;
  logic                    w_land_floor;
  logic signed [VW-1:0]    w_vy_dec;
  logic signed [VW-1:0]    w_vy_next;
  logic signed [31:0]      w_launch_prod;
  logic signed [VW-1:0]    w_launch_vy;
  logic signed [VW-1:0]    w_launch_vx;
  logic                    w_walk_off;

  function automatic logic [PHY_WIDTH-1:0] clamp_x(input logic signed [SW-1:0] v);
    logic [PHY_WIDTH-1:0] res;
    if (v < C_XMIN) begin
      res = C_XMIN[PHY_WIDTH-1:0];
    end else if (v > C_XMAX) begin
      res = C_XMAX[PHY_WIDTH-1:0];
    end else begin
      res = v[PHY_WIDTH-1:0];
    end
    return res;
  endfunction

  // Both buttons held cancel out: no motion and facing is kept.
  assign w_dir_l = bus.left  & ~bus.right;
  assign w_dir_r = bus.right & ~bus.left;

  assign w_x_ext = $signed({1'b0, r_x});
  assign w_y_ext = $signed({1'b0, r_y});

  // Walking step, clamped to the playable strip between the walls.
  always_comb begin
    w_walk_sum = w_x_ext;
    if (w_dir_r) begin
      w_walk_sum = w_x_ext + C_WALK;
    end else if (w_dir_l) begin
      w_walk_sum = w_x_ext - C_WALK;
    end
    w_walk_x = clamp_x(w_walk_sum);
  end

  // Horizontal flight step; leaving the strip counts as a wall hit.
  assign w_air_sum  = w_x_ext + SW'(r_vx);
  assign w_wall_hit = (w_air_sum < C_XMIN) || (w_air_sum > C_XMAX);
  assign w_air_x    = clamp_x(w_air_sum);

  // Vertical flight step. Landing is only considered at or after the apex,
  // so a platform passed on the way up does not catch the character.
  assign w_y_sum      = w_y_ext + SW'(r_vy);
  assign w_vy_falling = r_vy[VW-1] | (r_vy == '0);
  assign w_land_gnd   = w_vy_falling & bus.ground_hit;
  assign w_land_floor = w_vy_falling & (w_y_sum < C_FLOOR);

  always_comb begin
    if (w_y_sum > C_YMAX) begin
      w_air_y = C_YMAX[PHY_WIDTH-1:0];
    end else if (w_y_sum < C_FLOOR) begin
      w_air_y = C_FLOOR_U;
    end else begin
      w_air_y = w_y_sum[PHY_WIDTH-1:0];
    end
  end

  // Gravity with a terminal fall speed.
  assign w_vy_dec  = r_vy - C_GRAV;
  assign w_vy_next = (w_vy_dec < C_FALL_LIM) ? C_FALL_LIM : w_vy_dec;

  // Launch velocity: vertical from the stored charge, horizontal from the
  // direction held on the release tick.
  assign w_launch_prod = int'(r_charge) * JUMP_STEP_Y;
  assign w_launch_vy   = VW'(w_launch_prod);

  always_comb begin
    w_launch_vx = '0;
    if (w_dir_r) begin
      w_launch_vx = C_JUMP_VX;
    end else if (w_dir_l) begin
      w_launch_vx = -C_JUMP_VX;
    end
  end

  // Standing above the floor with nothing underneath: start falling.
  assign w_walk_off = ~bus.ground_hit && (r_y > C_FLOOR_U);

  // ---------------------------------------------------------------------------
  // Motion FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state      <= S_IDLE;
      r_x          <= C_INIT_X;
      r_y          <= C_FLOOR_U;
      r_vx         <= '0;
      r_vy         <= '0;
      r_charge     <= '0;
      r_facing     <= 1'b1;
      r_jump_start <= 1'b0;
      r_land       <= 1'b0;
    end else begin
      // Pulses only live for the cycle right after the tick that raised them.
      r_jump_start <= 1'b0;
      r_land       <= 1'b0;

      if (bus.phy_tick) begin
        case (r_state)
          S_IDLE: begin
            if (bus.jump) begin
              r_state  <= S_CHARGE;
              r_charge <= '0;
            end else begin
              r_x <= w_walk_x;
              if (w_dir_r) begin
                r_facing <= 1'b1;
              end else if (w_dir_l) begin
                r_facing <= 1'b0;
              end
              if (w_walk_off) begin
                r_state <= S_AIR;
                r_vx    <= '0;
                r_vy    <= '0;
              end
            end
          end

          S_CHARGE: begin
            if (bus.jump) begin
              if (r_charge < C_MAX_CHG) begin
                r_charge <= r_charge + 1'b1;
              end
            end else begin
              r_state      <= S_AIR;
              r_vy         <= w_launch_vy;
              r_vx         <= w_launch_vx;
              r_jump_start <= 1'b1;
              r_charge     <= '0;
              if (w_dir_r) begin
                r_facing <= 1'b1;
              end else if (w_dir_l) begin
                r_facing <= 1'b0;
              end
            end
          end

          S_AIR: begin
            r_x <= w_air_x;

            if (w_wall_hit) begin
`ifdef CHAR_WALL_BOUNCE_EN
              r_vx     <= -r_vx;
              r_facing <= ~r_facing;
`else
              r_vx     <= '0;
`endif
            end

            // Landing overrides the wall response on vx.
            if (w_land_gnd) begin
              r_y     <= bus.ground_y;
              r_vx    <= '0;
              r_vy    <= '0;
              r_state <= S_IDLE;
              r_land  <= 1'b1;
            end else if (w_land_floor) begin
              r_y     <= C_FLOOR_U;
              r_vx    <= '0;
              r_vy    <= '0;
              r_state <= S_IDLE;
              r_land  <= 1'b1;
            end else begin
              r_y  <= w_air_y;
              r_vy <= w_vy_next;
            end
          end

          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign bus.char_abs_x = r_x;
  assign bus.char_abs_y = r_y;
  assign bus.state      = r_state;
  assign bus.charge_lvl = r_charge;
  assign bus.facing     = r_facing;
  assign bus.jump_start = r_jump_start;
  assign bus.land       = r_land;

endmodule
